// File: rtl/uart_transmitter_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: data width, TX state
// encodings and the symbol-length computation.
package uart_transmitter_buffered_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Clock cycles per line symbol (integer divide).
    function automatic int unsigned symbol_cycles(input int unsigned clock_freq,
                                                  input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter. DEPTH must be a power of two
// so the pointers wrap naturally.
module uart_tx_fifo
    import uart_transmitter_buffered_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] din,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push_ok;
    logic                   pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Next-state: write at tail, advance head, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_transmitter_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are shifted
// out LSB-first on SOut. Define UART_TX_PARITY_EN to add an even-parity symbol
// between the data bits and the stop bit.
module uart_transmitter_buffered
    import uart_transmitter_buffered_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [UART_DATA_W-1:0] DataIn,
    input  logic                   DataInValid,
    output logic                   DataInReady,
    output logic                   SOut,
    output logic                   TxIdle
);

    localparam int unsigned SYMBOL_CYCLES = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SYM_W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
    localparam int unsigned BIT_W = $clog2(UART_DATA_W);

    tx_state_e              state_q, state_d;
    logic [SYM_W-1:0]       sym_cnt_q, sym_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   sout_q, sout_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif
    logic                   sym_last;
    logic                   fifo_pop_c;
    logic [UART_DATA_W-1:0] fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst_n (Reset),
        .push  (DataInValid),
        .din   (DataIn),
        .pop   (fifo_pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign sym_last    = (sym_cnt_q == SYM_W'(SYMBOL_CYCLES - 1));
    assign DataInReady = !fifo_full;
    assign TxIdle      = (state_q == TX_IDLE) && fifo_empty;
    assign SOut        = sout_q;

    // Frame sequencing; SOut is registered from the current state, so the
    // line lags the FSM by one cycle uniformly and frames stay exact.
    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sout_d     = 1'b1;
        fifo_pop_c = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != TX_IDLE) begin
            sym_cnt_d = sym_last ? '0 : sym_cnt_q + SYM_W'(1);
        end
        case (state_q)
            TX_IDLE: begin
                fifo_pop_c = !fifo_empty;
            end
            TX_START: begin
                sout_d = 1'b0;
                if (sym_last) state_d = TX_DATA;
            end
            TX_DATA: begin
                sout_d = shift_q[0];
                if (sym_last) begin
                    shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
                    if (bit_cnt_q == BIT_W'(UART_DATA_W - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = TX_PARITY;
`else
                        state_d   = TX_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                sout_d = parity_q;
                if (sym_last) state_d = TX_STOP;
            end
`endif
            TX_STOP: begin
                sout_d = 1'b1;
                if (sym_last) begin
                    if (!fifo_empty) fifo_pop_c = 1'b1;
                    else             state_d    = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
        // Loading a new byte always restarts the frame from START.
        if (fifo_pop_c) begin
            shift_d   = fifo_dout;
            sym_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = TX_START;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_dout;
`endif
        end
    end

    // State registers; line idles high out of reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= TX_IDLE;
            sym_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sout_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sout_q    <= sout_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
